// File: rtl/duck_motion_if.sv
// Sprite-draw handshake between a duck controller and the sprite drawer.
//   x_out/y_out : position to draw, stable while draw_req is high
//   draw_req    : controller has a new position pending
//   draw_ack    : drawer has latched x_out/y_out
// master = duck controller, slave = sprite drawer.
interface duck_motion_if;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic       draw_req;
  logic       draw_ack;

  modport master (output x_out, output y_out, output draw_req, input draw_ack);
  modport slave  (input x_out, input y_out, input draw_req, output draw_ack);
endinterface

// File: rtl/duck_motion.sv
// Per-duck position and life-cycle controller for a 160x120 playfield.
// Steps the duck once per accepted tick with edge bounces, handles hit,
// fall and escape, and offers every new position over the draw handshake.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   tick         : one-cycle step pulse
//   shot_hit     : one-cycle hit pulse (only meaningful in FLY)
//   respawn      : one-cycle launch pulse (only meaningful in IDLE/GONE)
//   draw         : duck_motion_if master (x_out, y_out, draw_req, draw_ack)
//   state_out    : 0 IDLE, 1 FLY, 2 FALL, 3 GONE
//   escaped      : one-cycle pulse, duck left through the top edge
//   downed       : one-cycle pulse, shot duck reached the ground
module duck_motion #(
  parameter int X_MAX          = 152,
  parameter int Y_MAX          = 112,
  parameter int X_START        = 0,
  parameter int Y_START        = 100,
  parameter int ESCAPE_BOUNCES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic              shot_hit,
  input  logic              respawn,
  duck_motion_if.master     draw,
  output logic [1:0]        state_out,
  output logic              escaped,
  output logic              downed
);

  typedef enum logic [1:0] {IDLE = 2'd0, FLY = 2'd1, FALL = 2'd2, GONE = 2'd3} state_t;

  localparam logic [7:0] XMAX = 8'(X_MAX);
  localparam logic [6:0] YMAX = 7'(Y_MAX);
  localparam logic [7:0] XST  = 8'(X_START);
  localparam logic [6:0] YST  = 7'(Y_START);
  localparam logic [4:0] ESCB = 5'(ESCAPE_BOUNCES);

  state_t     state;
  logic [7:0] x;
  logic [6:0] y;
  logic       dx_neg, dy_neg;   // direction: 1 = moving toward 0
  logic [3:0] bounce_cnt;
  logic       req;

  // Next-step candidates for a FLY tick
  logic [7:0] nx;
  logic [6:0] ny;
  logic       ndx_neg, ndy_neg, x_bnc, y_bnc, y_esc;
  logic [4:0] bsum;
  logic [3:0] nbounce;

  always_comb begin
    nx      = x;
    ndx_neg = dx_neg;
    x_bnc   = 1'b0;
    if (!dx_neg && x == XMAX) begin
      ndx_neg = 1'b1; nx = XMAX - 8'd1; x_bnc = 1'b1;
    end else if (dx_neg && x == 8'd0) begin
      ndx_neg = 1'b0; nx = 8'd1; x_bnc = 1'b1;
    end else begin
      nx = dx_neg ? x - 8'd1 : x + 8'd1;
    end

    ny      = y;
    ndy_neg = dy_neg;
    y_bnc   = 1'b0;
    y_esc   = 1'b0;
    if (!dy_neg && y == YMAX) begin
      ndy_neg = 1'b1; ny = YMAX - 7'd1; y_bnc = 1'b1;
    end else if (dy_neg && y == 7'd0) begin
      // top edge is an exit only once the duck has bounced enough
      if ({1'b0, bounce_cnt} >= ESCB) y_esc = 1'b1;
      else begin
        ndy_neg = 1'b0; ny = 7'd1; y_bnc = 1'b1;
      end
    end else begin
      ny = dy_neg ? y - 7'd1 : y + 7'd1;
    end

    // corner hit counts as two bounces; saturate at 15
    bsum    = {1'b0, bounce_cnt} + {4'd0, x_bnc} + {4'd0, y_bnc};
    nbounce = bsum[4] ? 4'hF : bsum[3:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      x          <= XST;
      y          <= YST;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b1;
      bounce_cnt <= 4'd0;
      req        <= 1'b0;
      escaped    <= 1'b0;
      downed     <= 1'b0;
    end else begin
      escaped <= 1'b0;
      downed  <= 1'b0;
      if (req && draw.draw_ack) req <= 1'b0;
      case (state)
        IDLE, GONE: begin
          if (respawn) begin
            state      <= FLY;
            x          <= XST;
            y          <= YST;
            dx_neg     <= 1'b0;
            dy_neg     <= 1'b1;
            bounce_cnt <= 4'd0;
            req        <= 1'b1;
          end
        end
        FLY: begin
          if (shot_hit) begin
            state <= FALL;
          end else if (tick && !req) begin
            if (y_esc) begin
              // position held, nothing to draw
              state   <= GONE;
              escaped <= 1'b1;
            end else begin
              x          <= nx;
              y          <= ny;
              dx_neg     <= ndx_neg;
              dy_neg     <= ndy_neg;
              bounce_cnt <= nbounce;
              req        <= 1'b1;
            end
          end
        end
        FALL: begin
          if (tick && !req) begin
            req <= 1'b1;
            if (y >= YMAX - 7'd2) begin
              y      <= YMAX;
              state  <= GONE;
              downed <= 1'b1;
            end else begin
              y <= y + 7'd2;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign draw.x_out    = x;
  assign draw.y_out    = y;
  assign draw.draw_req = req;
  assign state_out     = state;

endmodule

// File: tb/tb_duck_motion.sv
module tb_duck_motion;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // index 0: default params; 1: small field, immediate escape; 2: small field, escape after 4 bounces
  logic [2:0] tick = '0, shot = '0, resp = '0, ack = '0;
  logic [2:0] req, esc, dwn;
  logic [7:0] xo [3];
  logic [6:0] yo [3];
  logic [1:0] st [3];

  duck_motion_if dif0 ();
  duck_motion_if dif1 ();
  duck_motion_if dif2 ();

  duck_motion u0 (.clk(clk), .reset_n(rst_n), .tick(tick[0]), .shot_hit(shot[0]), .respawn(resp[0]),
                  .draw(dif0.master), .state_out(st[0]), .escaped(esc[0]), .downed(dwn[0]));
  duck_motion #(.X_MAX(4), .X_START(3), .Y_START(1), .ESCAPE_BOUNCES(0)) u1 (
                  .clk(clk), .reset_n(rst_n), .tick(tick[1]), .shot_hit(shot[1]), .respawn(resp[1]),
                  .draw(dif1.master), .state_out(st[1]), .escaped(esc[1]), .downed(dwn[1]));
  duck_motion #(.X_MAX(4), .X_START(3), .Y_START(1), .ESCAPE_BOUNCES(4)) u2 (
                  .clk(clk), .reset_n(rst_n), .tick(tick[2]), .shot_hit(shot[2]), .respawn(resp[2]),
                  .draw(dif2.master), .state_out(st[2]), .escaped(esc[2]), .downed(dwn[2]));

  assign dif0.draw_ack = ack[0];
  assign dif1.draw_ack = ack[1];
  assign dif2.draw_ack = ack[2];
  assign req = {dif2.draw_req, dif1.draw_req, dif0.draw_req};
  assign xo[0] = dif0.x_out; assign yo[0] = dif0.y_out;
  assign xo[1] = dif1.x_out; assign yo[1] = dif1.y_out;
  assign xo[2] = dif2.x_out; assign yo[2] = dif2.y_out;

  // kind: 0 draw, 1 escaped, 2 downed
  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] x;
    logic [6:0] y;
    logic [1:0] st;
    logic       req;
  } ev_t;

  ev_t exp_q [3][$];
  int total = 0;
  int bad = 0;

  // Monitors: any new draw_req, escaped or downed is an event to match
  for (genvar g = 0; g < 3; g++) begin : g_mon
    logic prev_req = 1'b0;
    always @(negedge clk) begin
      ev_t o, e;
      if ((req[g] && !prev_req) || esc[g] || dwn[g]) begin
        o.kind = esc[g] ? 2'd1 : (dwn[g] ? 2'd2 : 2'd0);
        o.x = xo[g]; o.y = yo[g]; o.st = st[g]; o.req = req[g];
        total++;
        if (exp_q[g].size() == 0) begin
          bad++;
          $display("FAIL unexpected_event dut%0d got kind=%0d x=%0d y=%0d st=%0d req=%0d",
                   g, o.kind, o.x, o.y, o.st, o.req);
        end else begin
          e = exp_q[g].pop_front();
          if (o !== e) begin
            bad++;
            $display("FAIL event dut%0d got kind=%0d x=%0d y=%0d st=%0d req=%0d want kind=%0d x=%0d y=%0d st=%0d req=%0d",
                     g, o.kind, o.x, o.y, o.st, o.req, e.kind, e.x, e.y, e.st, e.req);
          end
        end
      end
      prev_req <= req[g];
    end
  end

  task automatic expect_ev(input int i, input int kind, input int x, input int y, input int s, input int r);
    ev_t e;
    e.kind = 2'(kind); e.x = 8'(x); e.y = 7'(y); e.st = 2'(s); e.req = 1'(r);
    exp_q[i].push_back(e);
  endtask

  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  task automatic pulse(input int i, input bit t, input bit s, input bit r, input bit a);
    @(negedge clk);
    tick[i] = t; shot[i] = s; resp[i] = r; ack[i] = a;
    @(negedge clk);
    tick[i] = 1'b0; shot[i] = 1'b0; resp[i] = 1'b0; ack[i] = 1'b0;
  endtask

  task automatic do_tick(input int i); pulse(i, 1, 0, 0, 0); endtask
  task automatic do_resp(input int i); pulse(i, 0, 0, 1, 0); endtask
  task automatic do_ack(input int i);
    pulse(i, 0, 0, 0, 1);
    check($sformatf("req_clear_dut%0d", i), int'(req[i]), 0);
  endtask

  initial begin
    int xs [6];
    int ys [6];
    xs = '{4, 3, 2, 1, 0, 1};
    ys = '{0, 1, 2, 3, 4, 5};

    repeat (2) @(negedge clk);
    check("rst_state", int'(st[0]), 0);
    check("rst_x", int'(xo[0]), 0);
    check("rst_y", int'(yo[0]), 100);
    check("rst_req", int'(req[0]), 0);
    check("rst_x_small", int'(xo[1]), 3);
    check("rst_y_small", int'(yo[1]), 1);
    rst_n = 1'b1;

    // hit and fall
    expect_ev(0, 0, 0, 100, 1, 1);
    do_resp(0);
    do_ack(0);
    pulse(0, 1, 1, 0, 0);            // shot_hit wins over tick
    check("shot_state", int'(st[0]), 2);
    check("shot_y", int'(yo[0]), 100);
    check("shot_no_req", int'(req[0]), 0);
    for (int k = 1; k <= 5; k++) begin
      expect_ev(0, 0, 0, 100 + 2 * k, 2, 1);
      do_tick(0);
      do_ack(0);
    end
    expect_ev(0, 2, 0, 112, 3, 1);
    do_tick(0);
    do_ack(0);

    // respawn from GONE, then fly
    expect_ev(0, 0, 0, 100, 1, 1);
    do_resp(0);
    do_ack(0);
    expect_ev(0, 0, 1, 99, 1, 1);
    do_tick(0);
    do_ack(0);
    expect_ev(0, 0, 2, 98, 1, 1);
    do_tick(0);
    do_tick(0);                      // dropped: draw still pending
    check("drop_x", int'(xo[0]), 2);
    check("drop_y", int'(yo[0]), 98);
    do_ack(0);
    expect_ev(0, 0, 3, 97, 1, 1);
    do_tick(0);
    pulse(0, 1, 0, 0, 1);            // tick alongside ack is dropped too
    check("ack_tick_req", int'(req[0]), 0);
    check("ack_tick_y", int'(yo[0]), 97);
    do_resp(0);                      // ignored while flying
    check("resp_fly_state", int'(st[0]), 1);
    check("resp_fly_x", int'(xo[0]), 3);

    // immediate escape at the top edge
    expect_ev(1, 0, 3, 1, 1, 1);
    do_resp(1);
    do_ack(1);
    expect_ev(1, 0, 4, 0, 1, 1);
    do_tick(1);
    do_ack(1);
    expect_ev(1, 1, 4, 0, 3, 0);
    do_tick(1);

    // corner bounce, then x bounce at 0, no escape
    expect_ev(2, 0, 3, 1, 1, 1);
    do_resp(2);
    do_ack(2);
    for (int k = 0; k < 6; k++) begin
      expect_ev(2, 0, xs[k], ys[k], 1, 1);
      do_tick(2);
      do_ack(2);
    end

    // async reset mid-FALL with a draw pending
    pulse(0, 0, 1, 0, 0);
    expect_ev(0, 0, 3, 99, 2, 1);
    do_tick(0);
    check("pre_rst_req", int'(req[0]), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", int'(st[0]), 0);
    check("arst_x", int'(xo[0]), 0);
    check("arst_y", int'(yo[0]), 100);
    check("arst_req", int'(req[0]), 0);
    check("arst_state_small", int'(st[1]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("q_empty_dut%0d", i), exp_q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/duck_motion.md
# duck_motion

Per-duck position and life-cycle controller for the DuckHunt playfield (160x120 VGA adapter coordinates). Consumes the one-cycle frame-rate tick produced by the 15-cycle pacing counter, advances the duck one step per tick with edge bounces, and handles hit, fall and escape. Every position change is offered to the sprite drawer through a req/ack handshake.

## Interface
- X_MAX, 152: largest legal x (160 minus 8-pixel sprite width)
- Y_MAX, 112: largest legal y (120 minus 8-pixel sprite height)
- X_START, 0: x loaded on respawn
- Y_START, 100: y loaded on respawn
- ESCAPE_BOUNCES, 4: bounces required before the top edge becomes an exit
- clk  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle step pulse from the pacing counter (at most one per 15 clocks)
- shot_hit  input  1  one-cycle pulse: the gun scored a hit on this duck
- respawn  input  1  one-cycle pulse: launch a new duck
- draw_ack  input  1  sprite drawer has latched x_out/y_out
- x_out  output  8  current duck x
- y_out  output  7  current duck y
- draw_req  output  1  x_out/y_out hold a new position to draw
- state_out  output  2  0 IDLE, 1 FLY, 2 FALL, 3 GONE
- escaped  output  1  one-cycle pulse: duck left through top edge
- downed  output  1  one-cycle pulse: shot duck reached the ground

## Operation
- Reset values: state IDLE, x_out=X_START, y_out=Y_START, dx=+1, dy=-1, bounce_cnt=0, draw_req=0, escaped=0, downed=0.
- IDLE / GONE: respawn -> FLY; load x=X_START, y=Y_START, dx=+1, dy=-1, bounce_cnt=0; draw_req<=1. tick, shot_hit ignored.
- FLY, shot_hit=1 -> FALL; position unchanged; has priority over a same-cycle tick.
- FLY, tick=1, draw_req=0 (per axis, same edge):
  - x: dx=+1 and x==X_MAX -> dx<=-1, x<=X_MAX-1, bounce; dx=-1 and x==0 -> dx<=+1, x<=1, bounce; else x<=x+dx.
  - y: dy=+1 and y==Y_MAX -> dy<=-1, y<=Y_MAX-1, bounce; dy=-1 and y==0 and bounce_cnt>=ESCAPE_BOUNCES -> GONE, escaped pulse, no draw_req, x also held; dy=-1 and y==0 otherwise -> dy<=+1, y<=1, bounce; else y<=y+dy.
  - bounce_cnt increments by number of bouncing axes (corner = 2), saturates at 15 (4-bit).
  - draw_req<=1 unless transitioning to GONE.
- FALL, tick=1, draw_req=0: x held; if y>=Y_MAX-2 -> y<=Y_MAX, state GONE, downed pulse, draw_req<=1 (final frame); else y<=y+2, draw_req<=1.
- Ticks arriving while draw_req=1 are dropped, not queued. shot_hit and respawn are still evaluated.
- respawn in FLY or FALL ignored. shot_hit outside FLY ignored.
- draw_req clears on the edge where draw_ack=1 is sampled; x_out/y_out stable while draw_req=1. draw_ack with draw_req=0 ignored.
- Unsigned arithmetic; x 8-bit, y 7-bit; edge checks ensure no wrap (x never <0 or >X_MAX, y never >Y_MAX).

## Timing
- Latency: tick/respawn sampled at edge N -> new x_out/y_out and draw_req=1 visible after edge N.
- escaped/downed high exactly one cycle, coincident with state_out changing to GONE.
- draw_req falls one edge after draw_ack sampled high; a tick in that same cycle is still dropped (draw_req was 1).
- reset_n low at any time, including mid-FALL or with draw_req=1: all outputs return to reset values immediately, independent of clk.

## Test plan
- Reset, respawn -> state_out=1, x_out=0, y_out=100, draw_req=1; draw_ack one cycle -> draw_req=0 next cycle; tick -> x_out=1, y_out=99.
- X_MAX=4, X_START=3, Y_START=50: ticks with prompt acks -> x 4, 3 (dx flips), bounce_cnt=1; y 49, 48.
- Y_START=1, ESCAPE_BOUNCES=0: tick -> y=0; next tick -> state_out=3, escaped=1 one cycle, draw_req=0; ESCAPE_BOUNCES=4 same stimulus -> y=1, dy=+1, no escape.
- shot_hit and tick same cycle at y=100 -> state FALL, y unchanged; ticks -> 102, 104 ... 110, then y=112, downed=1, state GONE.
- Tick while draw_req=1 (ack withheld) -> position unchanged, tick lost; after ack next tick advances one step only.
- reset_n pulsed low mid-FALL with draw_req=1 -> state_out=0, x_out=0, y_out=100, draw_req=0 without waiting for clk.
